// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : MEM-stage sequencer for LDR/LDB/LDI/STR/STB/STI and trap reads.
//            It drives the dcache handshake, stalls the pipeline during the
//            access and registers the loaded word for the byte/trap selector.
//            Optional perf counters are compiled in when MEM_ACCESS_PERF_EN
//            is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
  parameter int ADDR_W = 16,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_load,
  input  logic              req_store,
  input  logic              req_indirect,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_wdata,
  output logic              dcache_read,
  output logic              dcache_write,
  output logic [ADDR_W-1:0] dcache_address,
  output logic [ADDR_W-1:0] dcache_wdata,
  output logic [1:0]        dcache_byte_enable,
  input  logic              dcache_resp,
  input  logic [ADDR_W-1:0] dcache_rdata,
  output logic              mem_stall,
  output logic              mem_done,
  output logic [ADDR_W-1:0] dcache_out,
  output logic              mem_bit,
`ifdef MEM_ACCESS_PERF_EN
  output logic [PERF_W-1:0] perf_loads,
  output logic [PERF_W-1:0] perf_stores,
  output logic [PERF_W-1:0] perf_wait_cycles,
`endif
  output logic              byte_check
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_IND_RD = 3'd1,
    S_ACC_RD = 3'd2,
    S_ACC_WR = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  if (PERF_W < 1) begin : g_perf_w_check
    $error("PERF_W must be at least 1");
  end

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_wdata;
  logic              r_load;
  logic              r_byte;
  logic [ADDR_W-1:0] r_dcache_out;
  logic              r_mem_bit;
  logic              r_byte_check;

  logic              w_mem_req;
  logic [ADDR_W-1:0] w_word_addr;
  logic [ADDR_W-1:0] w_final_addr;
  logic [ADDR_W-1:0] w_byte_wdata;

  assign w_mem_req    = req_valid && (req_load || req_store);
  assign w_word_addr  = {r_addr[ADDR_W-1:1], 1'b0};
  // Byte accesses keep bit 0 so the cache can steer the lane; word accesses align.
  assign w_final_addr = r_byte ? r_addr : w_word_addr;
  assign w_byte_wdata = {(ADDR_W/8){r_wdata[7:0]}};

  always_comb begin
    w_next_state       = r_state;
    dcache_read        = 1'b0;
    dcache_write       = 1'b0;
    dcache_address     = '0;
    dcache_wdata       = '0;
    dcache_byte_enable = 2'b00;
    mem_done           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_req) begin
          if (req_indirect)  w_next_state = S_IND_RD;
          else if (req_load) w_next_state = S_ACC_RD;
          else               w_next_state = S_ACC_WR;
        end
      end
      S_IND_RD: begin
        dcache_read    = 1'b1;
        dcache_address = w_word_addr;
        if (dcache_resp) w_next_state = r_load ? S_ACC_RD : S_ACC_WR;
      end
      S_ACC_RD: begin
        dcache_read    = 1'b1;
        dcache_address = w_final_addr;
        if (dcache_resp) w_next_state = S_DONE;
      end
      S_ACC_WR: begin
        dcache_write   = 1'b1;
        dcache_address = w_final_addr;
        if (r_byte) begin
          dcache_wdata       = w_byte_wdata;
          dcache_byte_enable = r_addr[0] ? 2'b10 : 2'b01;
        end else begin
          dcache_wdata       = r_wdata;
          dcache_byte_enable = 2'b11;
        end
        if (dcache_resp) w_next_state = S_DONE;
      end
      S_DONE: begin
        mem_done     = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Combinational so the pipeline freezes in the very cycle a request is accepted.
  assign mem_stall = w_mem_req && (r_state != S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_load       <= 1'b0;
      r_byte       <= 1'b0;
      r_dcache_out <= '0;
      r_mem_bit    <= 1'b0;
      r_byte_check <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_IDLE && w_mem_req) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_load  <= req_load;
        r_byte  <= req_byte;
      end
      if (r_state == S_IND_RD && dcache_resp) begin
        r_addr <= dcache_rdata;
      end
      if (r_state == S_ACC_RD && dcache_resp) begin
        r_dcache_out <= dcache_rdata;
        r_mem_bit    <= r_addr[0];
        r_byte_check <= r_byte;
      end
    end
  end

  assign dcache_out = r_dcache_out;
  assign mem_bit    = r_mem_bit;
  assign byte_check = r_byte_check;

`ifdef MEM_ACCESS_PERF_EN
  logic [PERF_W-1:0] r_perf_loads;
  logic [PERF_W-1:0] r_perf_stores;
  logic [PERF_W-1:0] r_perf_wait;
  logic              w_wait_cycle;

  assign w_wait_cycle = (dcache_read || dcache_write) && !dcache_resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_loads  <= '0;
      r_perf_stores <= '0;
      r_perf_wait   <= '0;
    end else begin
      if (r_state == S_ACC_RD && dcache_resp && !(&r_perf_loads))
        r_perf_loads <= r_perf_loads + 1'b1;
      if (r_state == S_ACC_WR && dcache_resp && !(&r_perf_stores))
        r_perf_stores <= r_perf_stores + 1'b1;
      if (w_wait_cycle && !(&r_perf_wait))
        r_perf_wait <= r_perf_wait + 1'b1;
    end
  end

  assign perf_loads       = r_perf_loads;
  assign perf_stores      = r_perf_stores;
  assign perf_wait_cycles = r_perf_wait;
`endif

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage access controller sitting directly upstream of the load-byte/trap data selector. It sits between the pipeline's MEM stage and the data cache.
- Sequences LDR/LDB/LDI/STR/STB/STI and trap-vector reads into dcache read/write handshakes, including two-access indirect operations.
- Stalls the pipeline for the whole access.
- Registers the returned word. Presents word, byte-lane select bit and byte flag to the downstream selector.

Parameters:
- ADDR_W, 16, address and data word width (lc3b_word width).
- PERF_W, 16, width of the optional performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  MEM stage holds a memory instruction
- req_load  in  1  read access (LDR/LDB/LDI/TRAP)
- req_store  in  1  write access (STR/STB/STI)
- req_indirect  in  1  LDI/STI: first fetch pointer from req_addr
- req_byte  in  1  byte-sized access (LDB/STB)
- req_addr  in  ADDR_W  effective address
- req_wdata  in  ADDR_W  store data
- dcache_read  out  1  read request
- dcache_write  out  1  write request
- dcache_address  out  ADDR_W  access address
- dcache_wdata  out  ADDR_W  write data
- dcache_byte_enable  out  2  write lane enables
- dcache_resp  in  1  access complete
- dcache_rdata  in  ADDR_W  read data
- mem_stall  out  1  hold pipeline
- mem_done  out  1  one-cycle completion pulse
- dcache_out  out  ADDR_W  registered read word
- mem_bit  out  1  latched final address bit 0
- byte_check  out  1  latched req_byte of last completed load

Behaviour:
- States:
  - IDLE: no access in progress.
  - IND_RD: pointer fetch for an indirect access.
  - ACC_RD: final read access.
  - ACC_WR: final write access.
  - DONE: completion cycle.
- Reset values:
  - State is IDLE.
  - All outputs are 0 (dcache_byte_enable=2'b00, dcache_out=0).
- IDLE:
  - Triggers on req_valid && (req_load || req_store).
  - Latches addr, wdata, load/store, byte and indirect flags.
  - Next state: IND_RD if indirect, else ACC_RD (load) or ACC_WR (store).
  - If req_load and req_store are both set, load wins.
- Request timing:
  - dcache_read/dcache_write assert on the edge entering the access state.
  - Both are held with a stable address/data until the cycle dcache_resp=1.
  - Both are deasserted on the following edge.
  - dcache_resp is sampled only in IND_RD/ACC_RD/ACC_WR and ignored elsewhere.
- IND_RD:
  - Word read at {addr[15:1],1'b0}.
  - On resp, dcache_rdata replaces the latched address. The next state is ACC_RD or ACC_WR.
  - The indirect pointer is always treated as a word.
- ACC_RD:
  - Address is the latched address. dcache_address carries full bit 0 for byte loads and has bit 0 cleared for word loads.
  - On resp: dcache_out <= dcache_rdata, mem_bit <= addr[0], byte_check <= req_byte. Go to DONE.
- ACC_WR:
  - Word store: byte_enable=2'b11, address bit 0 cleared, wdata=store data.
  - Byte store: byte_enable = addr[0] ? 2'b10 : 2'b01, wdata = {data[7:0],data[7:0]}.
  - On resp go to DONE.
  - dcache_out, mem_bit and byte_check are unchanged by stores.
- DONE:
  - mem_done=1 and mem_stall=0 for exactly one cycle, then IDLE.
  - The pipeline advances on this cycle. A new req seen in IDLE the following cycle starts a new access.
- mem_stall = req_valid && (req_load||req_store) && state!=DONE. This is combinational, so it is high in the IDLE cycle of acceptance.
- Minimum latency, resp in the first request cycle:
  - Direct access: 3 cycles accept→done.
  - Indirect access: 4 cycles.
- Non-memory req_valid (neither load nor store): no stall, stays IDLE.
- dcache_out, mem_bit and byte_check hold until the next load completes.
- Reset mid-operation: next edge goes to IDLE with requests deasserted. The registered outputs are cleared.

Optional Feature:
- Macro MEM_ACCESS_PERF_EN. When defined, adds three outputs, each PERF_W bits:
  - perf_loads: completed loads.
  - perf_stores: completed stores.
  - perf_wait_cycles: cycles with dcache_read or dcache_write high and dcache_resp low.
- All three counters saturate at all-ones and clear on rst.
- When undefined, the ports and logic are absent. Behaviour is otherwise identical.

Test Plan:
- LDR addr=0x1234, resp after 2 wait cycles with rdata=0xBEEF → dcache_address=0x1234, dcache_read high 3 cycles, dcache_out=0xBEEF, mem_bit=0, byte_check=0, mem_done pulses once.
- LDB addr=0x3001, rdata=0xA55A → dcache_address=0x3001, dcache_out=0xA55A, mem_bit=1, byte_check=1.
- STB addr=0x4003, wdata=0x12CD → dcache_write with byte_enable=2'b10, wdata=0xCDCD, address 0x4003. dcache_out unchanged.
- LDI addr=0x2001: first read at 0x2000 returns 0x5000, second read returns 0x0042 → second dcache_address=0x5000, dcache_out=0x0042, total 4 cycles with immediate resp.
- rst asserted while in ACC_WR with dcache_write high → next cycle dcache_write=0, state IDLE, mem_stall follows req_valid. A stray dcache_resp in IDLE is ignored.
- With MEM_ACCESS_PERF_EN: two loads plus one store with 3 total wait cycles → perf_loads=2, perf_stores=1, perf_wait_cycles=3.
